// File: rtl/kugelblitz_capture_if.sv
// Bundle of the monitored AXI-stream tap and the AXI-lite register port
// used by kugelblitz_capture; master is the bus owner, slave is the capture block.
interface kugelblitz_capture_if #(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0]      s_axis_tdata;
  logic [KEEP_WIDTH-1:0]      s_axis_tkeep;
  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic                       s_axis_tlast;

  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr;
  logic [2:0]                 s_axil_awprot;
  logic                       s_axil_awvalid;
  logic                       s_axil_awready;
  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata;
  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb;
  logic                       s_axil_wvalid;
  logic                       s_axil_wready;
  logic [1:0]                 s_axil_bresp;
  logic                       s_axil_bvalid;
  logic                       s_axil_bready;
  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr;
  logic [2:0]                 s_axil_arprot;
  logic                       s_axil_arvalid;
  logic                       s_axil_arready;
  logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata;
  logic [1:0]                 s_axil_rresp;
  logic                       s_axil_rvalid;
  logic                       s_axil_rready;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tready, s_axis_tlast,
    output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
    output s_axil_wdata, s_axil_wstrb, s_axil_wvalid, s_axil_bready,
    output s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
    input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tready, s_axis_tlast,
    input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
    input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid, s_axil_bready,
    input  s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
    output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
    output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid
  );
endinterface

// File: rtl/kugelblitz_capture.sv
// Passive AXI-stream tap capturing a 4-byte window of one frame, exposed over AXI-lite.
// Optional frame counter at 0x10 is built when KUGELBLITZ_CAPTURE_FRAME_COUNT_EN is defined.
module kugelblitz_capture #(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
) (
  input logic                  clk,
  input logic                  rst_n,
  kugelblitz_capture_if.slave  bus
);
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [DATA_WIDTH-1:0]      tdata;
  logic [KEEP_WIDTH-1:0]      tkeep;
  logic [AXIL_DATA_WIDTH-1:0] wdata;
  logic [AXIL_STRB_WIDTH-1:0] wstrb;
  logic [AXIL_DATA_WIDTH-1:0] rd_val;
  logic [AXIL_DATA_WIDTH-1:0] rdata;
  logic [AXIL_DATA_WIDTH-1:0] data;
  logic [AXIL_DATA_WIDTH-1:0] fc_val;
  logic [31:0]                cap;
  logic [31:0]                cap_nxt;
  logic [3:0]                 valid;
  logic [3:0]                 valid_nxt;
  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic [15:0]                offset;
  logic [9:0]                 beat_idx;
  logic [2:0]                 wr_sel;
  logic [2:0]                 rd_sel;
  logic sof, cont, done_flag, short_flag, armed;
  logic awready, wready, bvalid, arready, rvalid;
  logic beat_acc, eval_en, complete, short_end, fin;
  logic wr_hs, rd_hs, ctrl_wr, arm_wr, abort_wr, data_rd;
  logic unused_bits;

  function automatic logic [16:0] win_pos(input logic [15:0] off, input logic [1:0] idx);
    return {1'b0, off} + {15'b0, idx};
  endfunction

  assign tdata = bus.s_axis_tdata;
  assign tkeep = bus.s_axis_tkeep;
  assign wdata = bus.s_axil_wdata;
  assign wstrb = bus.s_axil_wstrb;

  assign bus.s_axil_awready = awready;
  assign bus.s_axil_wready  = wready;
  assign bus.s_axil_bvalid  = bvalid;
  assign bus.s_axil_bresp   = 2'b00;
  assign bus.s_axil_arready = arready;
  assign bus.s_axil_rvalid  = rvalid;
  assign bus.s_axil_rdata   = rdata;
  assign bus.s_axil_rresp   = 2'b00;

  assign unused_bits = ^{bus.s_axil_awaddr[AXIL_ADDR_WIDTH-1:5], bus.s_axil_awaddr[1:0],
                         bus.s_axil_araddr[AXIL_ADDR_WIDTH-1:5], bus.s_axil_araddr[1:0],
                         bus.s_axil_awprot, bus.s_axil_arprot, wstrb[3:2], wdata[31:16]};

  assign wr_sel   = bus.s_axil_awaddr[4:2];
  assign rd_sel   = bus.s_axil_araddr[4:2];
  assign wr_hs    = awready && bus.s_axil_awvalid && wready && bus.s_axil_wvalid;
  assign rd_hs    = arready && bus.s_axil_arvalid;
  assign ctrl_wr  = wr_hs && (wr_sel == 3'd0) && wstrb[0];
  assign arm_wr   = ctrl_wr && wdata[0];
  assign abort_wr = ctrl_wr && !wdata[0] && !wdata[1] && armed;
  assign data_rd  = rd_hs && (rd_sel == 3'd3);

  assign armed     = (state == ST_WAIT_SOF) || (state == ST_CAPTURE);
  assign beat_acc  = bus.s_axis_tvalid && bus.s_axis_tready;
  assign eval_en   = beat_acc && ((state == ST_CAPTURE) || ((state == ST_WAIT_SOF) && sof));
  assign complete  = eval_en && (valid_nxt == 4'hF);
  assign short_end = eval_en && !complete && bus.s_axis_tlast;
  // A register write on the same edge overrides the stream outcome.
  assign fin       = (complete || short_end) && !arm_wr && !abort_wr;

  // Merge window bytes present in the current beat into the capture register.
  always_comb begin
    logic [16:0] p;
    p         = 17'd0;
    cap_nxt   = cap;
    valid_nxt = valid;
    for (int i = 0; i < 4; i++) begin
      p = win_pos(offset, 2'(i));
      if ((p[16:6] == {1'b0, beat_idx}) && tkeep[p[5:0]]) begin
        cap_nxt[8*i +: 8] = tdata[{p[5:0], 3'b000} +: 8];
        valid_nxt[i]      = 1'b1;
      end else begin
        valid_nxt[i] = valid[i];
      end
    end
  end

  // Capture FSM next state.
  always_comb begin
    state_nxt = state;
    if (arm_wr) begin
      state_nxt = ST_WAIT_SOF;
    end else if (abort_wr) begin
      state_nxt = ST_IDLE;
    end else if (complete || short_end) begin
      state_nxt = cont ? ST_WAIT_SOF : ST_DONE;
    end else if (eval_en) begin
      state_nxt = ST_CAPTURE;
    end else if (state == ST_DONE) begin
      state_nxt = ST_IDLE;
    end else begin
      state_nxt = state;
    end
  end

  // Register read multiplexer.
  always_comb begin
    case (rd_sel)
      3'd0:    rd_val = {30'd0, cont, 1'b0};
      3'd1:    rd_val = {16'd0, offset};
      3'd2:    rd_val = {29'd0, short_flag, done_flag, armed};
      3'd3:    rd_val = data;
      3'd4:    rd_val = fc_val;
      default: rd_val = 32'd0;
    endcase
  end

  // Frame boundary tracking on accepted beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sof      <= 1'b1;
      beat_idx <= 10'd0;
    end else if (beat_acc) begin
      sof      <= bus.s_axis_tlast;
      beat_idx <= bus.s_axis_tlast ? 10'd0 :
                  (beat_idx == 10'd1023) ? 10'd1023 : beat_idx + 10'd1;
    end else begin
      sof      <= sof;
      beat_idx <= beat_idx;
    end
  end

  // FSM state, capture working set, latched DATA and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cap        <= 32'd0;
      valid      <= 4'd0;
      data       <= 32'd0;
      done_flag  <= 1'b0;
      short_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm_wr || fin) begin
        cap   <= 32'd0;
        valid <= 4'd0;
      end else if (eval_en) begin
        cap   <= cap_nxt;
        valid <= valid_nxt;
      end
      if (fin) begin
        data       <= cap_nxt;
        done_flag  <= 1'b1;
        short_flag <= short_end;
      end else if (data_rd) begin
        done_flag  <= 1'b0;
        short_flag <= 1'b0;
      end
    end
  end

  // Host-writable configuration with per-byte strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cont   <= 1'b0;
      offset <= 16'd0;
    end else begin
      if (ctrl_wr) begin
        cont <= wdata[1];
      end
      if (wr_hs && (wr_sel == 3'd1)) begin
        if (wstrb[0]) offset[7:0]  <= wdata[7:0];
        if (wstrb[1]) offset[15:8] <= wdata[15:8];
      end
    end
  end

  // AXI-lite write and read channel handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      awready <= bus.s_axil_awvalid && bus.s_axil_wvalid && !bvalid && !awready;
      wready  <= bus.s_axil_awvalid && bus.s_axil_wvalid && !bvalid && !awready;
      if (wr_hs) begin
        bvalid <= 1'b1;
      end else if (bvalid && bus.s_axil_bready) begin
        bvalid <= 1'b0;
      end
      arready <= bus.s_axil_arvalid && !rvalid && !arready;
      if (rd_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end else if (rvalid && bus.s_axil_rready) begin
        rvalid <= 1'b0;
      end
    end
  end

`ifdef KUGELBLITZ_CAPTURE_FRAME_COUNT_EN
  logic [31:0] frame_count;

  // Count accepted end-of-frame beats, wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count <= 32'd0;
    end else if (beat_acc && bus.s_axis_tlast) begin
      frame_count <= frame_count + 32'd1;
    end else begin
      frame_count <= frame_count;
    end
  end

  assign fc_val = frame_count;
`else
  assign fc_val = 32'd0;
`endif
endmodule
